seq_right_shifter: RTL and testbench

//   Multi-cycle right shifter for the ALU's SRL/SRA path; the right-hand counterpart of the

---
 rtl/seq_right_shifter.sv | 124 ++++++++++++
 tb/tb_seq_right_shifter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_right_shifter.sv
// seq_right_shifter: multi-cycle SRL/SRA unit, one bit per clock (four per clock when SHIFT_STEP4_EN is defined).
// Latency: done pulses N edges after the sampling edge (floor(N/4)+N%4 with SHIFT_STEP4_EN); throughput one op per latency+2 cycles.
// Backpressure: start is accepted only while ready=1; starts during SHIFT/DONE are dropped, never queued.
module seq_right_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
`ifdef SHIFT_STEP4_EN
  localparam logic [SHAMT_W-1:0] CNT_FOUR = SHAMT_W'(4);
`endif

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   shift_reg;
  logic [WIDTH-1:0]   shift_step;
  logic [SHAMT_W-1:0] count;
  logic [SHAMT_W-1:0] count_step;
  logic               mode;
  logic               fill;
  logic               accept;

  // A start is only honoured from IDLE; everything else ignores it.
  assign accept = (state == IDLE) && start;

  // Fill bit: sign bit for arithmetic shifts, zero for logical shifts.
  assign fill = mode & shift_reg[WIDTH-1];

  // One shift step of the datapath and the matching count decrement.
  always_comb begin
    shift_step = {fill, shift_reg[WIDTH-1:1]};
    count_step = count - CNT_ONE;
`ifdef SHIFT_STEP4_EN
    if (count >= CNT_FOUR) begin
      shift_step = {{4{fill}}, shift_reg[WIDTH-1:4]};
      count_step = count - CNT_FOUR;
    end
`endif
  end

  // State register; reset aborts any shift in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: zero-length shifts go straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (shamt == CNT_ZERO) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (count_step == CNT_ZERO) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: status flags come straight from the state.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      SHIFT:   busy  = 1'b1;
      DONE:    done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Datapath: capture operands on accept, step while shifting, otherwise hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      count     <= '0;
      mode      <= 1'b0;
    end else if (accept) begin
      shift_reg <= data_in;
      count     <= shamt;
      mode      <= arith;
    end else if (state == SHIFT) begin
      shift_reg <= shift_step;
      count     <= count_step;
    end
  end

  // Result holds until the next accepted start.
  assign result = shift_reg;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Self-checking bench for seq_right_shifter: directed cases plus random operations
// against an arithmetic reference model (>> / >>> and a closed-form latency).
module tb_seq_right_shifter;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        arith;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int compared   = 0;
  int mismatched = 0;

  seq_right_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .shamt   (shamt),
    .arith   (arith),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: shift result from plain arithmetic operators.
  function automatic logic [31:0] ref_result(input logic [31:0] d, input int n, input logic a);
    logic signed [31:0] sd;
    sd = d;
    if (a) return 32'(sd >>> n);
    return d >> n;
  endfunction

  // Reference: number of clock edges from sampling edge to done.
  function automatic int ref_latency(input int n);
`ifdef SHIFT_STEP4_EN
    return (n / 4) + (n % 4);
`else
    return n;
`endif
  endfunction

  // Issue one op (caller is #1 after an edge with the DUT idle), wait for done, check it.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] n,
                        input logic a, input bit noisy);
    int cycles;
    int busy_cycles;
    logic [31:0] exp_res;
    exp_res = ref_result(d, int'(n), a);
    chk({tag, "_ready_before"}, 32'(ready), 32'd1);
    start   = 1'b1;
    data_in = d;
    shamt   = n;
    arith   = a;
    @(posedge clock);
    #1;
    start       = 1'b0;
    data_in     = $urandom;
    shamt       = 5'($urandom);
    arith       = 1'($urandom);
    cycles      = 0;
    busy_cycles = 0;
    while (!done && cycles < 200) begin
      if (busy) busy_cycles++;
      start   = noisy ? 1'($urandom) : 1'b0;
      data_in = $urandom;
      shamt   = 5'($urandom);
      @(posedge clock);
      #1;
      cycles++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(cycles), 32'(ref_latency(int'(n))));
    chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(ref_latency(int'(n))));
    chk({tag, "_result"}, result, exp_res);
    @(posedge clock);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_ready_after"}, 32'(ready), 32'd1);
    chk({tag, "_result_hold"}, result, exp_res);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;
    shamt   = '0;
    arith   = 1'b0;
    #2;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Directed cases: saturation, zero shift, ignored start while busy, mixed step sizes.
    run_op("t1_srl31", 32'h8000_0000, 5'd31, 1'b0, 1'b0);
    run_op("t2_sra31", 32'h8000_0000, 5'd31, 1'b1, 1'b0);
    run_op("t3_zero", 32'h1234_5678, 5'd0, 1'b0, 1'b0);
    run_op("t4_noisy", 32'h0000_F000, 5'd4, 1'b0, 1'b1);
    run_op("t6_sra13", 32'hF000_0000, 5'd13, 1'b1, 1'b0);
    run_op("t_pos_sra", 32'h7FFF_FFFF, 5'd30, 1'b1, 1'b0);

    // Explicit ignored-start check: a second start mid-shift must not alter the result.
    start   = 1'b1;
    data_in = 32'h0000_F000;
    shamt   = 5'd4;
    arith   = 1'b0;
    @(posedge clock);
    #1;
    start   = 1'b1;
    data_in = 32'hFFFF_FFFF;
    shamt   = 5'd1;
    arith   = 1'b1;
    chk("t4b_busy", 32'(busy), 32'd1);
    @(posedge clock);
    #1;
    start = 1'b0;
    begin
      int guard = 0;
      while (!done && guard < 50) begin
        @(posedge clock);
        #1;
        guard++;
      end
    end
    chk("t4b_done", 32'(done), 32'd1);
    chk("t4b_result", result, 32'h0000_0F00);
    @(posedge clock);
    #1;
    chk("t4b_ready", 32'(ready), 32'd1);

    // Reset mid-shift aborts immediately.
    start   = 1'b1;
    data_in = 32'hDEAD_BEEF;
    shamt   = 5'd20;
    arith   = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    chk("t5_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_ready", 32'(ready), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_result", result, 32'd0);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    run_op("t5_after", 32'hDEAD_BEEF, 5'd20, 1'b1, 1'b0);

    // Random operations with random start noise while busy.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] rd;
      logic [4:0]  rn;
      logic        ra;
      rd = $urandom;
      rn = 5'($urandom_range(0, 31));
      ra = 1'($urandom);
      run_op("rand", rd, rn, ra, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
